br_trace_sched: RTL and testbench

//  Sequencer for the branch-trace generator in the BPU unit-test bench. Asserts the

---
 rtl/br_trace_pkg.sv | 33 +++
 rtl/br_trace_sched_if.sv | 52 +++++
 rtl/br_trace_fifo.sv | 61 ++++++
 rtl/br_trace_sched.sv | 141 ++++++++++++++
 tb/tb_br_trace_sched.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/br_trace_pkg.sv
// Shared types and constants for the branch-trace sequencer.
package br_trace_pkg;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned BT_W  = 2;
    localparam int unsigned REG_W = 5;

    // One branch record as produced by the trace generator (77 bits)
    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [PC_W-1:0]  target;
        logic [BT_W-1:0]  br_type;
        logic             taken;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rd;
    } br_rec_t;

    localparam logic [BT_W-1:0] BR_COND = 2'd0;
    localparam logic [BT_W-1:0] BR_JAL  = 2'd1;
    localparam logic [BT_W-1:0] BR_JALR = 2'd2;
    localparam logic [BT_W-1:0] BR_RET  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // A record with this pc marks the end of the trace
    localparam logic [PC_W-1:0] PC_SENTINEL = 32'h0;

endpackage

// File: rtl/br_trace_sched_if.sv
// Control, generator and consumer signals of the branch-trace sequencer.
interface br_trace_sched_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic             start;
    logic             stop_req;
    logic [CNT_W-1:0] rec_limit;

    logic             gen_valid;
    logic [31:0]      gen_pc;
    logic [31:0]      gen_target;
    logic [1:0]       gen_br_type;
    logic             gen_taken;
    logic [4:0]       gen_rs1;
    logic [4:0]       gen_rd;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_target;
    logic [1:0]       out_br_type;
    logic             out_taken;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rd;

    logic             busy;
    logic             done;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] taken_cnt;

    // Sequencer side
    modport slave (
        input  start, stop_req, rec_limit,
        output gen_valid,
        input  gen_pc, gen_target, gen_br_type, gen_taken, gen_rs1, gen_rd,
        output out_valid,
        input  out_ready,
        output out_pc, out_target, out_br_type, out_taken, out_rs1, out_rd,
        output busy, done, issued_cnt, taken_cnt
    );

    // Bench / environment side
    modport master (
        output start, stop_req, rec_limit,
        input  gen_valid,
        output gen_pc, gen_target, gen_br_type, gen_taken, gen_rs1, gen_rd,
        input  out_valid,
        output out_ready,
        input  out_pc, out_target, out_br_type, out_taken, out_rs1, out_rd,
        input  busy, done, issued_cnt, taken_cnt
    );
endinterface

// File: rtl/br_trace_fifo.sv
// First-word-fall-through record buffer; enqueue and dequeue may coincide at any occupancy.
module br_trace_fifo
    import br_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_enq,
    input  br_rec_t                    i_data,
    input  logic                       i_deq,
    output br_rec_t                    o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    br_rec_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_do_enq;
    logic            w_do_deq;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rptr];
    // A dequeue frees the slot in the same cycle, so a full buffer may still accept
    assign w_do_deq = i_deq && !o_empty;
    assign w_do_enq = i_enq && (!o_full || w_do_deq);

    // Storage is cleared on reset so the head fields read zero out of reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_enq) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_enq) r_wptr <= r_wptr + AW'(1);
            if (w_do_deq) r_rptr <= r_rptr + AW'(1);
            if (w_do_enq && !w_do_deq)      r_count <= r_count + CW'(1);
            else if (!w_do_enq && w_do_deq) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/br_trace_sched.sv
// Branch-trace sequencer: pulls records from the generator, buffers and issues them.
module br_trace_sched
    import br_trace_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    br_trace_sched_if.slave   bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_limit;
    logic [CNT_W-1:0] r_fetched;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_taken;

    br_rec_t          w_rec;
    br_rec_t          w_head;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_gen_valid;
    logic             w_sentinel;
    logic             w_enq;
    logic             w_hs;
    logic             w_limit_hit;
    logic             w_clear;
    logic             w_busy;
    logic             w_done;

    assign w_rec.pc      = bus.gen_pc;
    assign w_rec.target  = bus.gen_target;
    assign w_rec.br_type = bus.gen_br_type;
    assign w_rec.taken   = bus.gen_taken;
    assign w_rec.rs1     = bus.gen_rs1;
    assign w_rec.rd      = bus.gen_rd;

    assign w_sentinel  = (w_rec.pc == PC_SENTINEL);
    assign w_enq       = w_gen_valid && !w_sentinel;
    assign w_hs        = !w_empty && bus.out_ready;
    // Limit counts the record being consumed this cycle
    assign w_limit_hit = (r_limit != '0) && w_enq && ((r_fetched + CNT_W'(1)) == r_limit);

    br_trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_enq   (w_enq),
        .i_data  (w_rec),
        .i_deq   (bus.out_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and state-decoded strobes
    always_comb begin
        w_next      = r_state;
        w_clear     = 1'b0;
        w_gen_valid = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next  = S_FETCH;
                    w_clear = 1'b1;
                end
            end
            S_FETCH: begin
                w_busy      = 1'b1;
                w_gen_valid = !w_full;
                if ((w_gen_valid && w_sentinel) || w_limit_hit || bus.stop_req) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (w_empty || ((w_count == CW'(1)) && w_hs)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_next  = S_FETCH;
                    w_clear = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Run counters and latched limit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_limit   <= '0;
            r_fetched <= '0;
            r_issued  <= '0;
            r_taken   <= '0;
        end else if (w_clear) begin
            r_limit   <= bus.rec_limit;
            r_fetched <= '0;
            r_issued  <= '0;
            r_taken   <= '0;
        end else begin
            if (w_enq) r_fetched <= r_fetched + CNT_W'(1);
            if (w_hs) begin
                r_issued <= r_issued + CNT_W'(1);
                r_taken  <= r_taken + CNT_W'(w_head.taken);
            end
        end
    end

    assign bus.gen_valid   = w_gen_valid;
    assign bus.out_valid   = !w_empty;
    assign bus.out_pc      = w_head.pc;
    assign bus.out_target  = w_head.target;
    assign bus.out_br_type = w_head.br_type;
    assign bus.out_taken   = w_head.taken;
    assign bus.out_rs1     = w_head.rs1;
    assign bus.out_rd      = w_head.rd;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.issued_cnt  = r_issued;
    assign bus.taken_cnt   = r_taken;

endmodule

// File: tb/tb_br_trace_sched.sv
// Directed bench for br_trace_sched with a queue-driven trace generator model.
module tb_br_trace_sched;
    import br_trace_pkg::*;

    logic clock;
    logic reset;

    br_trace_sched_if #(.CNT_W(32)) bus ();

    br_trace_sched #(
        .FIFO_DEPTH (4),
        .CNT_W      (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_chk;
    int          n_bad;
    int          g_idx;
    int          gv_cnt;
    logic [31:0] g_pc  [$];
    logic        g_tk  [$];
    logic [31:0] got_pc[$];
    logic [31:0] got_tg[$];

    // Single comparison point: counts and reports
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present the current generator record (sentinel once the table runs out)
    task automatic drive_gen();
        logic [31:0] pc;
        pc = (g_idx < g_pc.size()) ? g_pc[g_idx] : PC_SENTINEL;
        bus.gen_pc      = pc;
        bus.gen_target  = pc + 32'h40;
        bus.gen_br_type = pc[5:4];
        bus.gen_taken   = (g_idx < g_tk.size()) ? g_tk[g_idx] : 1'b0;
        bus.gen_rs1     = pc[8:4];
        bus.gen_rd      = pc[12:8];
    endtask

    task automatic gen_reset();
        g_pc.delete();
        g_tk.delete();
        got_pc.delete();
        got_tg.delete();
        g_idx  = 0;
        gv_cnt = 0;
    endtask

    task automatic add_rec(input logic [31:0] pc, input logic tk);
        g_pc.push_back(pc);
        g_tk.push_back(tk);
    endtask

    // One clock: observe pre-edge strobes, advance the generator on a consumed record
    task automatic tick();
        logic gv;
        logic hs;
        gv = bus.gen_valid;
        hs = bus.out_valid && bus.out_ready;
        if (hs) begin
            got_pc.push_back(bus.out_pc);
            got_tg.push_back(bus.out_target);
        end
        if (gv) gv_cnt++;
        @(posedge clock);
        #1;
        if (gv) begin
            g_idx++;
            drive_gen();
        end
    endtask

    task automatic do_start(input logic [31:0] lim);
        bus.rec_limit = lim;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int lim);
        int n;
        n = 0;
        while (!bus.done && n < lim) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.done), 32'd1);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        gen_reset();
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.stop_req  = 1'b0;
        bus.rec_limit = '0;
        bus.out_ready = 1'b0;
        drive_gen();
        #3 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_gen_valid", 32'(bus.gen_valid), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_done",      32'(bus.done),      32'd0);
        chk("rst_issued",    bus.issued_cnt,     32'd0);
        chk("rst_taken",     bus.taken_cnt,      32'd0);
        chk("rst_out_pc",    bus.out_pc,         32'd0);
        reset = 1'b1;
        tick();
        chk("idle_gen_valid", 32'(bus.gen_valid), 32'd0);

        // 1: three records then sentinel, consumer always ready
        gen_reset();
        add_rec(32'h10, 1'b1); add_rec(32'h20, 1'b0); add_rec(32'h30, 1'b1);
        drive_gen();
        bus.out_ready = 1'b1;
        do_start(32'd0);
        run_until_done("t1_done", 40);
        chk("t1_issued", bus.issued_cnt, 32'd3);
        chk("t1_taken",  bus.taken_cnt,  32'd2);
        chk("t1_gv",     32'(gv_cnt),    32'd4);
        chk("t1_n",      32'(got_pc.size()), 32'd3);
        chk("t1_pc0",    got_pc[0], 32'h10);
        chk("t1_pc1",    got_pc[1], 32'h20);
        chk("t1_pc2",    got_pc[2], 32'h30);
        chk("t1_tg2",    got_tg[2], 32'h70);
        chk("t1_busy",   32'(bus.busy), 32'd0);

        // 2: consumer stalled, buffer fills, head holds; then release
        gen_reset();
        add_rec(32'h200, 1'b1); add_rec(32'h210, 1'b1); add_rec(32'h220, 1'b0);
        add_rec(32'h230, 1'b0); add_rec(32'h240, 1'b1); add_rec(32'h250, 1'b0);
        drive_gen();
        bus.out_ready = 1'b0;
        do_start(32'd0);
        repeat (8) tick();
        chk("t2_gv_fill",  32'(gv_cnt),        32'd4);
        chk("t2_gv_full",  32'(bus.gen_valid), 32'd0);
        chk("t2_head",     bus.out_pc,         32'h200);
        repeat (3) tick();
        chk("t2_head_hold", bus.out_pc,         32'h200);
        chk("t2_ov_hold",   32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        run_until_done("t2_done", 60);
        chk("t2_n",      32'(got_pc.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("t2_pc%0d", i), got_pc[i], 32'h200 + 32'(i) * 32'h10);
        chk("t2_issued", bus.issued_cnt, 32'd6);
        chk("t2_taken",  bus.taken_cnt,  32'd3);
        chk("t2_gv",     32'(gv_cnt),    32'd7);

        // 3: record limit of two
        gen_reset();
        for (int i = 0; i < 5; i++) add_rec(32'h300 + 32'(i) * 32'h10, 1'b1);
        drive_gen();
        do_start(32'd2);
        run_until_done("t3_done", 40);
        chk("t3_gv",     32'(gv_cnt),    32'd2);
        chk("t3_issued", bus.issued_cnt, 32'd2);
        chk("t3_pc1",    got_pc[1],      32'h310);

        // 4: stop request on the first consumed record
        gen_reset();
        add_rec(32'h100, 1'b0); add_rec(32'h104, 1'b1); add_rec(32'h108, 1'b1);
        drive_gen();
        bus.out_ready = 1'b0;
        do_start(32'd0);
        bus.stop_req = 1'b1;
        tick();
        bus.stop_req = 1'b0;
        chk("t4_gv_off", 32'(bus.gen_valid), 32'd0);
        chk("t4_busy",   32'(bus.busy),      32'd1);
        chk("t4_head",   bus.out_pc,         32'h100);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t4_start_ign", 32'(bus.gen_valid), 32'd0);
        bus.out_ready = 1'b1;
        run_until_done("t4_done", 20);
        chk("t4_issued", bus.issued_cnt, 32'd1);
        chk("t4_pc0",    got_pc[0],      32'h100);
        chk("t4_gv",     32'(gv_cnt),    32'd1);
        bus.stop_req = 1'b1;
        tick();
        bus.stop_req = 1'b0;
        chk("t4_stop_ign", 32'(bus.done), 32'd1);

        // 5: full buffer streaming with simultaneous enqueue and dequeue
        gen_reset();
        add_rec(32'h500, 1'b1); add_rec(32'h510, 1'b0); add_rec(32'h520, 1'b1); add_rec(32'h530, 1'b1);
        add_rec(32'h540, 1'b0); add_rec(32'h550, 1'b0); add_rec(32'h560, 1'b1); add_rec(32'h570, 1'b0);
        drive_gen();
        bus.out_ready = 1'b0;
        do_start(32'd0);
        repeat (6) tick();
        chk("t5_full", 32'(bus.gen_valid), 32'd0);
        bus.out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (bus.issued_cnt != 32'd4 && n < 20) begin
                tick();
                n++;
            end
        end
        chk("t5_issued4", bus.issued_cnt,        32'd4);
        chk("t5_taken4",  bus.taken_cnt,         32'd3);
        chk("t5_gv_flow", 32'(bus.gen_valid),    32'd1);
        chk("t5_ov_flow", 32'(bus.out_valid),    32'd1);
        chk("t5_head",    bus.out_pc,            32'h540);
        bus.stop_req = 1'b1;
        tick();
        bus.stop_req = 1'b0;
        run_until_done("t5_done", 20);
        chk("t5_n", 32'(got_pc.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("t5_pc%0d", i), got_pc[i], 32'h500 + 32'(i) * 32'h10);
        chk("t5_issued", bus.issued_cnt, 32'd8);
        chk("t5_taken",  bus.taken_cnt,  32'd4);
        chk("t5_gv",     32'(gv_cnt),    32'd8);

        // 6: reset in DRAIN with two records buffered, then a clean run
        gen_reset();
        for (int i = 0; i < 5; i++) add_rec(32'h600 + 32'(i) * 32'h10, 1'b1);
        drive_gen();
        bus.out_ready = 1'b0;
        do_start(32'd0);
        tick();
        tick();
        bus.out_ready = 1'b1;
        bus.stop_req  = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.stop_req  = 1'b0;
        chk("t6_busy",   32'(bus.busy),  32'd1);
        chk("t6_issued", bus.issued_cnt, 32'd1);
        chk("t6_head",   bus.out_pc,     32'h610);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_ov",     32'(bus.out_valid), 32'd0);
        chk("t6_rst_busy",   32'(bus.busy),      32'd0);
        chk("t6_rst_issued", bus.issued_cnt,     32'd0);
        chk("t6_rst_taken",  bus.taken_cnt,      32'd0);
        chk("t6_rst_gv",     32'(bus.gen_valid), 32'd0);
        chk("t6_rst_pc",     bus.out_pc,         32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        gen_reset();
        add_rec(32'h700, 1'b1); add_rec(32'h710, 1'b1);
        drive_gen();
        bus.out_ready = 1'b1;
        do_start(32'd0);
        run_until_done("t6_done", 30);
        chk("t6_issued2", bus.issued_cnt, 32'd2);
        chk("t6_taken2",  bus.taken_cnt,  32'd2);
        chk("t6_pc0",     got_pc[0],      32'h700);
        chk("t6_pc1",     got_pc[1],      32'h710);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
